ls_unit_p: RTL and testbench
============================

Name: ls_unit_p

Overview:
- Parametrised load/store execution unit; next generation of the single-slot LS stage.
- Sits between the LS buffer and the memory controller.
- Accepts one memory op at a time: computes the effective address, drives a byte/half/word request, sign- or zero-extends load data, then reports completion (tag, name, data) to the ROB/CDB.
- Adds configurable widths, a ready/valid handshake toward the buffer, an extension unit, and optional misalignment trapping.

Parameters:
- DATA_W, 32, width of operands, immediate, load/store data and CDB data.
- ADDR_W, 17, memory address width; the effective address is truncated to this width.
- TAG_W, 4, ROB/RS tag width.
- NAME_W, 5, destination register name width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  global stall; freezes all state and outputs.
- LSworkEn  in  1  valid op from the LS buffer this cycle.
- operandO  in  DATA_W  base address register value.
- operandT  in  DATA_W  store data.
- imm  in  DATA_W  sign-extended offset.
- wrtTag  in  TAG_W  ROB tag of the op.
- wrtName  in  NAME_W  destination register name.
- opCode  in  4  bit3 = store; bits[2:0] = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- LSreadEn  out  1  unit can accept an op this cycle.
- LSfree  in  1  memory controller can take a request.
- dataEn  out  1  memory request valid (one-cycle pulse).
- LSRW  out  1  0 = read, 1 = write.
- dataAddr  out  ADDR_W  effective address.
- LSlen  out  2  bytes minus 1 (0 = B, 1 = H, 3 = W).
- Sdata  out  DATA_W  store data, low bytes valid.
- LOutEn  in  1  memory completion strobe (loads and stores).
- Ldata  in  DATA_W  raw load data, low bytes valid.
- outEn  out  1  completion valid to ROB/CDB (one-cycle pulse).
- outTag  out  TAG_W  tag of the completed op.
- outName  out  NAME_W  destination name (0 for stores).
- outData  out  DATA_W  extended load value (0 for stores).
- outExcept  out  1  misaligned-access flag (feature only, else tied 0).

Behaviour:
- Reset (async, rst = 1): state IDLE; LSreadEn = 1; dataEn, LSRW, LSlen, dataAddr, Sdata, outEn, outTag, outName, outData, outExcept all 0; latched op cleared.
- Stall: when stall = 1, no state, register or output changes; pulses are held, not repeated. The LS buffer and the memory controller observe the same stall.
- State IDLE:
  - LSreadEn = 1.
  - On LSworkEn, latch: addr = (operandO + imm)[ADDR_W-1:0] (wrap-around on overflow), opCode, operandT, wrtTag, wrtName.
  - Go to REQ; LSreadEn drops to 0 the next cycle.
- State REQ:
  - Wait for LSfree = 1.
  - In the cycle LSfree is seen, register dataEn = 1 for exactly one cycle with LSRW, dataAddr, LSlen and Sdata = operandT masked to len; go to WAIT.
- State WAIT:
  - Wait for LOutEn.
  - Loads: outData = B → sext(Ldata[7:0]), BU → zext(Ldata[7:0]), H → sext(Ldata[15:0]), HU → zext(Ldata[15:0]), W → Ldata[DATA_W-1:0].
  - Stores: outData = 0, outName = 0.
  - Register outEn = 1 with outTag for one cycle; go to IDLE.
- Latency, LSworkEn to outEn: 2 + (cycles waiting for LSfree) + memory latency + 1. Minimum back-to-back issue is one op per 4 cycles.
- LOutEn in IDLE or REQ is ignored, e.g. a stale response after reset.
- Undefined funct3 (011, 110, 111): treated as W.
- LSworkEn while LSreadEn = 0 is ignored; the buffer must hold the op.
- A new op is not accepted in the same cycle outEn is raised; LSreadEn rises together with outEn.

Optional Feature:
- Macro: LS_MISALIGN_TRAP_EN.
- Defined:
  - In REQ, an H access with addr[0] ≠ 0, or a W access with addr[1:0] ≠ 0, issues no memory request.
  - The next cycle drives outEn = 1, outExcept = 1, outTag, outData = 0 and returns to IDLE.
- Undefined: no check; the access is issued as-is and outExcept is tied 0.

Test Plan:
- Reset mid-WAIT: assert rst, then pulse LOutEn → all outputs 0, LSreadEn = 1, no outEn.
- LB: operandO = 0x100, imm = 0x3, Ldata = 0x80, tag 5, name 7 → dataAddr = 0x103, LSlen = 0, LSRW = 0; then outEn with outData = 0xFFFFFF80, outTag = 5, outName = 7.
- LHU: Ldata = 0x0000_8001 → outData = 0x00008001. LH with the same data → 0xFFFF8001.
- SW: operandO = 0x1FFFC, imm = 0x8 → dataAddr wraps to 0x00004; LSRW = 1, LSlen = 3, Sdata = operandT; on LOutEn, outEn with outData = 0 and outName = 0.
- LSfree held 0 for 5 cycles, with stall = 1 for 2 cycles during WAIT → dataEn issued exactly once when LSfree = 1; outEn pulse is 1 cycle long and delayed by exactly 2 cycles.
- With LS_MISALIGN_TRAP_EN: LW at addr 0x102 → no dataEn; outEn with outExcept = 1 two cycles after acceptance. Without the macro: dataEn issued with dataAddr = 0x102.

Source files
------------

// File: rtl/ls_unit_p.sv
// Load/store execution unit: address gen, single memory request, load extension.
// Define LS_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module ls_unit_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              LSworkEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [TAG_W-1:0]  wrtTag,
  input  logic [NAME_W-1:0] wrtName,
  input  logic [3:0]        opCode,
  output logic              LSreadEn,
  input  logic              LSfree,
  output logic              dataEn,
  output logic              LSRW,
  output logic [ADDR_W-1:0] dataAddr,
  output logic [1:0]        LSlen,
  output logic [DATA_W-1:0] Sdata,
  input  logic              LOutEn,
  input  logic [DATA_W-1:0] Ldata,
  output logic              outEn,
  output logic [TAG_W-1:0]  outTag,
  output logic [NAME_W-1:0] outName,
  output logic [DATA_W-1:0] outData,
  output logic              outExcept
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] addr;
  logic [3:0]        op;
  logic [DATA_W-1:0] sdat;
  logic [TAG_W-1:0]  tag;
  logic [NAME_W-1:0] name;

  logic [ADDR_W-1:0] ea;
  logic [1:0]        len;
  logic [DATA_W-1:0] smask;
  logic [DATA_W-1:0] ext;
  logic              mis;
  logic              accept, issue, trap, done;
  logic              unused;

  // Effective address wraps within ADDR_W
  assign ea     = operandO[ADDR_W-1:0] + imm[ADDR_W-1:0];
  assign unused = ^{operandO[DATA_W-1:ADDR_W], imm[DATA_W-1:ADDR_W]};

  always_comb begin
    len = 2'd3;
    unique case (op[2:0])
      3'b000, 3'b100: len = 2'd0;
      3'b001, 3'b101: len = 2'd1;
      default:        len = 2'd3;
    endcase
  end

  always_comb begin
    smask = sdat;
    unique case (len)
      2'd0:    smask = {{(DATA_W-8){1'b0}}, sdat[7:0]};
      2'd1:    smask = {{(DATA_W-16){1'b0}}, sdat[15:0]};
      default: smask = sdat;
    endcase
  end

  always_comb begin
    ext = Ldata;
    unique case (op[2:0])
      3'b000:  ext = {{(DATA_W-8){Ldata[7]}}, Ldata[7:0]};
      3'b100:  ext = {{(DATA_W-8){1'b0}}, Ldata[7:0]};
      3'b001:  ext = {{(DATA_W-16){Ldata[15]}}, Ldata[15:0]};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, Ldata[15:0]};
      default: ext = Ldata;
    endcase
  end

`ifdef LS_MISALIGN_TRAP_EN
  assign mis = ((len == 2'd1) && addr[0]) ||
               ((len == 2'd3) && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign accept = (state == IDLE) && LSworkEn;
  assign trap   = (state == REQ) && mis;
  assign issue  = (state == REQ) && LSfree && !mis;
  assign done   = (state == WAIT) && LOutEn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (!stall) begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      accept:  nxt = REQ;
      trap:    nxt = IDLE;
      issue:   nxt = WAIT;
      done:    nxt = IDLE;
      default: nxt = state;
    endcase
  end

  always_comb begin
    LSreadEn = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      op       <= '0;
      sdat     <= '0;
      tag      <= '0;
      name     <= '0;
      dataEn   <= 1'b0;
      LSRW     <= 1'b0;
      dataAddr <= '0;
      LSlen    <= '0;
      Sdata    <= '0;
      outEn    <= 1'b0;
      outTag   <= '0;
      outName  <= '0;
      outData  <= '0;
    end else if (!stall) begin
      dataEn <= 1'b0;
      outEn  <= 1'b0;
      if (accept) begin
        addr <= ea;
        op   <= opCode;
        sdat <= operandT;
        tag  <= wrtTag;
        name <= wrtName;
      end
      if (issue) begin
        dataEn   <= 1'b1;
        LSRW     <= op[3];
        dataAddr <= addr;
        LSlen    <= len;
        Sdata    <= smask;
      end
      if (trap) begin
        outEn   <= 1'b1;
        outTag  <= tag;
        outName <= op[3] ? '0 : name;
        outData <= '0;
      end
      if (done) begin
        outEn   <= 1'b1;
        outTag  <= tag;
        outName <= op[3] ? '0 : name;
        outData <= op[3] ? '0 : ext;
      end
    end
  end

`ifdef LS_MISALIGN_TRAP_EN
  logic exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc <= 1'b0;
    end else if (!stall) begin
      exc <= trap;
    end
  end

  assign outExcept = exc;
`else
  assign outExcept = 1'b0;
`endif

endmodule

// File: tb/tb_ls_unit_p.sv
// Directed bench for ls_unit_p.
module tb_ls_unit_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        LSworkEn;
  logic [31:0] operandO, operandT, imm;
  logic [3:0]  wrtTag;
  logic [4:0]  wrtName;
  logic [3:0]  opCode;
  logic        LSreadEn;
  logic        LSfree;
  logic        dataEn;
  logic        LSRW;
  logic [16:0] dataAddr;
  logic [1:0]  LSlen;
  logic [31:0] Sdata;
  logic        LOutEn;
  logic [31:0] Ldata;
  logic        outEn;
  logic [3:0]  outTag;
  logic [4:0]  outName;
  logic [31:0] outData;
  logic        outExcept;

  int total  = 0;
  int passed = 0;

  ls_unit_p dut (
    .clk(clk), .rst(rst), .stall(stall),
    .LSworkEn(LSworkEn), .operandO(operandO), .operandT(operandT),
    .imm(imm), .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode),
    .LSreadEn(LSreadEn), .LSfree(LSfree), .dataEn(dataEn),
    .LSRW(LSRW), .dataAddr(dataAddr), .LSlen(LSlen), .Sdata(Sdata),
    .LOutEn(LOutEn), .Ldata(Ldata), .outEn(outEn), .outTag(outTag),
    .outName(outName), .outData(outData), .outExcept(outExcept)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", t, obs, exp);
  endtask

  task automatic accept_op(input logic [31:0] o, input logic [31:0] i,
                           input logic [31:0] t, input logic [3:0] opc,
                           input logic [3:0] tg, input logic [4:0] nm);
    chk("ready_idle", {31'd0, LSreadEn}, 32'd1);
    operandO = o;
    imm      = i;
    operandT = t;
    opCode   = opc;
    wrtTag   = tg;
    wrtName  = nm;
    LSworkEn = 1'b1;
    tick;
    LSworkEn = 1'b0;
    chk("busy", {31'd0, LSreadEn}, 32'd0);
  endtask

  task automatic complete(input logic [31:0] ld);
    Ldata  = ld;
    LOutEn = 1'b1;
    tick;
    LOutEn = 1'b0;
    chk("outEn", {31'd0, outEn}, 32'd1);
    chk("ready_done", {31'd0, LSreadEn}, 32'd1);
  endtask

  task automatic pulse_end;
    tick;
    chk("outEn_1cyc", {31'd0, outEn}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; LSworkEn = 1'b0;
    operandO = '0; operandT = '0; imm = '0;
    wrtTag = '0; wrtName = '0; opCode = '0;
    LSfree = 1'b1; LOutEn = 1'b0; Ldata = '0;
    tick;
    tick;
    chk("rst_ready", {31'd0, LSreadEn}, 32'd1);
    chk("rst_dataEn", {31'd0, dataEn}, 32'd0);
    chk("rst_outEn", {31'd0, outEn}, 32'd0);
    chk("rst_addr", {15'd0, dataAddr}, 32'd0);
    rst = 1'b0;
    tick;

    // LB with sign extension
    accept_op(32'h100, 32'h3, 32'h0, 4'b0000, 4'd5, 5'd7);
    tick;
    chk("lb_dataEn", {31'd0, dataEn}, 32'd1);
    chk("lb_addr", {15'd0, dataAddr}, 32'h103);
    chk("lb_len", {30'd0, LSlen}, 32'd0);
    chk("lb_rw", {31'd0, LSRW}, 32'd0);
    complete(32'h80);
    chk("lb_data", outData, 32'hFFFFFF80);
    chk("lb_tag", {28'd0, outTag}, 32'd5);
    chk("lb_name", {27'd0, outName}, 32'd7);
    pulse_end;

    // LHU / LH
    accept_op(32'h200, 32'h0, 32'h0, 4'b0101, 4'd1, 5'd2);
    tick;
    chk("lhu_len", {30'd0, LSlen}, 32'd1);
    complete(32'h0000_8001);
    chk("lhu_data", outData, 32'h0000_8001);
    pulse_end;
    accept_op(32'h200, 32'h0, 32'h0, 4'b0001, 4'd1, 5'd2);
    tick;
    complete(32'h0000_8001);
    chk("lh_data", outData, 32'hFFFF_8001);
    pulse_end;

    // LBU and undefined funct3 treated as W
    accept_op(32'h10, 32'h1, 32'h0, 4'b0100, 4'd3, 5'd3);
    tick;
    complete(32'hFFFF_FF80);
    chk("lbu_data", outData, 32'h0000_0080);
    pulse_end;
    accept_op(32'h400, 32'h0, 32'h0, 4'b0011, 4'd4, 5'd4);
    tick;
    chk("undef_len", {30'd0, LSlen}, 32'd3);
    complete(32'h89AB_CDEF);
    chk("undef_data", outData, 32'h89AB_CDEF);
    pulse_end;

    // SW with address wrap
    accept_op(32'h1FFFC, 32'h8, 32'hDEAD_BEEF, 4'b1010, 4'd3, 5'd9);
    tick;
    chk("sw_dataEn", {31'd0, dataEn}, 32'd1);
    chk("sw_addr", {15'd0, dataAddr}, 32'h4);
    chk("sw_rw", {31'd0, LSRW}, 32'd1);
    chk("sw_len", {30'd0, LSlen}, 32'd3);
    chk("sw_sdata", Sdata, 32'hDEAD_BEEF);
    complete(32'h1234_5678);
    chk("sw_data", outData, 32'd0);
    chk("sw_name", {27'd0, outName}, 32'd0);
    chk("sw_tag", {28'd0, outTag}, 32'd3);
    pulse_end;

    // SB masks store data
    accept_op(32'h20, 32'h0, 32'hDEAD_BEEF, 4'b1000, 4'd8, 5'd1);
    tick;
    chk("sb_sdata", Sdata, 32'h0000_00EF);
    complete(32'h0);
    pulse_end;

    // Stray LOutEn in IDLE is ignored
    LOutEn = 1'b1;
    tick;
    LOutEn = 1'b0;
    chk("idle_lout", {31'd0, outEn}, 32'd0);

    // LSfree held low, foreign LSworkEn ignored, stall in WAIT
    LSfree = 1'b0;
    accept_op(32'h300, 32'h0, 32'h0, 4'b0010, 4'd2, 5'd4);
    operandO = 32'h500;
    wrtTag   = 4'hF;
    LSworkEn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("free_wait", {31'd0, dataEn}, 32'd0);
    end
    LSworkEn = 1'b0;
    LSfree   = 1'b1;
    tick;
    LSfree = 1'b0;
    chk("free_dataEn", {31'd0, dataEn}, 32'd1);
    chk("free_addr", {15'd0, dataAddr}, 32'h300);
    tick;
    chk("free_once", {31'd0, dataEn}, 32'd0);
    Ldata  = 32'h1234_5678;
    LOutEn = 1'b1;
    stall  = 1'b1;
    tick;
    chk("stall_1", {31'd0, outEn}, 32'd0);
    tick;
    chk("stall_2", {31'd0, outEn}, 32'd0);
    stall = 1'b0;
    tick;
    LOutEn = 1'b0;
    chk("stall_outEn", {31'd0, outEn}, 32'd1);
    chk("stall_data", outData, 32'h1234_5678);
    chk("stall_tag", {28'd0, outTag}, 32'd2);
    stall = 1'b1;
    tick;
    chk("stall_hold", {31'd0, outEn}, 32'd1);
    stall  = 1'b0;
    LSfree = 1'b1;
    pulse_end;

    // Misaligned word
    accept_op(32'h100, 32'h2, 32'h0, 4'b0010, 4'd6, 5'd1);
    tick;
`ifdef LS_MISALIGN_TRAP_EN
    chk("mis_nodataEn", {31'd0, dataEn}, 32'd0);
    chk("mis_outEn", {31'd0, outEn}, 32'd1);
    chk("mis_exc", {31'd0, outExcept}, 32'd1);
    chk("mis_tag", {28'd0, outTag}, 32'd6);
    chk("mis_data", outData, 32'd0);
    pulse_end;
`else
    chk("mis_dataEn", {31'd0, dataEn}, 32'd1);
    chk("mis_addr", {15'd0, dataAddr}, 32'h102);
    complete(32'hCAFE_F00D);
    chk("mis_data", outData, 32'hCAFE_F00D);
    chk("mis_exc", {31'd0, outExcept}, 32'd0);
    pulse_end;
`endif

    // Reset in WAIT, stale response afterwards
    accept_op(32'h80, 32'h0, 32'h0, 4'b0010, 4'd9, 5'd3);
    tick;
    rst = 1'b1;
    tick;
    LOutEn = 1'b1;
    tick;
    chk("rw_outEn", {31'd0, outEn}, 32'd0);
    chk("rw_dataEn", {31'd0, dataEn}, 32'd0);
    chk("rw_ready", {31'd0, LSreadEn}, 32'd1);
    chk("rw_addr", {15'd0, dataAddr}, 32'd0);
    chk("rw_tag", {28'd0, outTag}, 32'd0);
    chk("rw_data", outData, 32'd0);
    rst = 1'b0;
    tick;
    LOutEn = 1'b0;
    chk("rw_stale", {31'd0, outEn}, 32'd0);
    chk("rw_ready2", {31'd0, LSreadEn}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
